ws2812_frame_streamer: RTL and testbench
========================================

WS2812_FRAME_STREAMER -- requirements
Module: ws2812_frame_streamer

Interface
REQ-001 Parameter NUM_PIXELS, default 64: pixels per frame; legal range is 1 to 1024.
REQ-002 Parameter BITS_PER_PIXEL, default 24: bits per pixel; legal values are 24 (GRB) and 32 (GRBW).
REQ-003 Parameter T0H, default 17: high-time of a 0 bit, in clk cycles.
REQ-004 Parameter T1H, default 35: high-time of a 1 bit, in clk cycles.
REQ-005 Parameter TBIT, default 62: total period of one bit, in clk cycles; T0H < T1H < TBIT shall hold.
REQ-006 Parameter TRESET, default 15000: low latch gap after a frame, in clk cycles.
REQ-007 Parameter FREE_RUN, default 0: 1 restarts a frame automatically after each latch gap; 0 waits for start.
REQ-008 clk  in  1  single clock; all logic runs on the rising edge.
REQ-009 rst  in  1  reset; asynchronous assertion, active-low.
REQ-010 start  in  1  one-cycle frame request; sampled only in IDLE.
REQ-011 pix_data  in  BITS_PER_PIXEL  pixel word; the MSB is transmitted first.
REQ-012 pix_valid  in  1  pix_data is valid.
REQ-013 pix_ready  out  1  block can accept a pixel word; a transfer occurs when pix_valid and pix_ready are both 1.
REQ-014 pix_index  out  clog2(NUM_PIXELS), min 1  index of the pixel that pix_ready is requesting.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse at the end of the latch gap.
REQ-017 underrun  out  1  one-cycle pulse when a black pixel is substituted for a missing pixel word.
REQ-018 dout  out  1  WS2812 serial line.

Function
REQ-019 The block shall implement a state machine with states IDLE, FIRST, SEND and LATCH.
REQ-020 IDLE: dout=0 and pix_ready=0; start=1, or FREE_RUN=1, shall move the block to FIRST with pix_index=0.
REQ-021 FIRST: pix_ready=1; on a transfer, the word shall load into the shift register, the bit counter and cycle counter shall clear, pix_index shall advance, and the state shall move to SEND on the next cycle; with no transfer, FIRST shall hold indefinitely with dout=0.
REQ-022 SEND, bit waveform: dout=1 while cycle counter < (current bit ? T1H : T0H), else dout=0; the cycle counter runs 0..TBIT-1.
REQ-023 SEND, prefetch: the block shall hold a one-word buffer; pix_ready=1 while the buffer is empty and pixels remain to be requested; a transfer shall fill the buffer and advance pix_index.
REQ-024 SEND, pixel boundary: on the last cycle of the last bit, the shift register shall load from the buffer and the buffer shall empty, so there is no gap between pixels.
REQ-025 Underrun: if the buffer is empty at a pixel boundary, the block shall load all zeros, advance pix_index, and pulse underrun; timing shall be unaffected.
REQ-026 After pixel NUM_PIXELS-1 has been sent in full, the block shall move to LATCH with dout=0; pix_ready shall stay 0 until the next frame.
REQ-027 LATCH: dout=0 for exactly TRESET cycles, then frame_done shall pulse and the block shall move to IDLE, or to FIRST if FREE_RUN=1.
REQ-028 start shall be ignored while busy=1.
REQ-029 pix_index shall stay at NUM_PIXELS-1 once all words are requested, and shall return to 0 only on entry to FIRST.
REQ-030 A frame shall be exactly NUM_PIXELS*BITS_PER_PIXEL*TBIT cycles from the first rising edge of dout to LATCH entry.
REQ-031 Counters shall be sized to hold the maximum of each parameter; no wrap-around shall occur inside a frame.

Reset
REQ-032 While rst=0: state=IDLE, all counters=0, buffer empty, shift register=0, dout=0, pix_ready=0, pix_index=0, busy=0, frame_done=0, underrun=0.
REQ-033 A reset asserted mid-frame shall abort the frame immediately; no further rising edges of dout shall occur until a new start.
REQ-034 On the first edge after rst is released, the block shall be in IDLE; start shall be accepted from that cycle.

Verification
REQ-035 Defaults, FREE_RUN=0, pix_data=24'hAA00FF with pix_valid held high, one start pulse -> 64 pixels; each bit is 35 high/27 low for a 1 and 17 high/45 low for a 0; frame is 95232 cycles; then 15000 low cycles; one frame_done pulse.
REQ-036 NUM_PIXELS=2, BITS_PER_PIXEL=32, pixels 32'h80000001 and 32'h00000000 -> first bit and bit 31 are 1-waveforms; all other bits are 0-waveforms; frame is 3968 cycles.
REQ-037 Defaults, pix_valid dropped for pixel 5 -> one underrun pulse; pixel 5 is sent as 24 zero bits; total frame length is unchanged.
REQ-038 start pulses during SEND and LATCH -> ignored; exactly one frame and one frame_done.
REQ-039 rst asserted at bit 10 of pixel 3 -> dout=0 and all outputs at reset values within the same cycle; dout remains low until a new start.
REQ-040 FREE_RUN=1 -> back-to-back frames separated by exactly TRESET low cycles; pix_index returns to 0 at each FIRST entry.

Source files
------------

// File: rtl/ws2812_frame_streamer.sv
// WS2812 frame streamer: pulls NUM_PIXELS pixel words over a valid/ready handshake and
// serialises them MSB-first onto a single WS2812 line, followed by a TRESET-cycle latch gap.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   start      - one-cycle frame request, only honoured in IDLE
//   pix_data   - pixel word (GRB or GRBW), MSB first on the line
//   pix_valid  - pix_data is valid
//   pix_ready  - block accepts a pixel word this cycle
//   pix_index  - index of the pixel currently being requested
//   busy       - high outside IDLE
//   frame_done - one-cycle pulse on the last cycle of the latch gap
//   underrun   - one-cycle pulse when a black pixel replaces a missing word
//   dout       - WS2812 serial line
module ws2812_frame_streamer #(
    parameter int unsigned NUM_PIXELS     = 64,
    parameter int unsigned BITS_PER_PIXEL = 24,
    parameter int unsigned T0H            = 17,
    parameter int unsigned T1H            = 35,
    parameter int unsigned TBIT           = 62,
    parameter int unsigned TRESET         = 15000,
    parameter bit          FREE_RUN       = 1'b0
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic [BITS_PER_PIXEL-1:0]                              pix_data,
    input  logic                                                   pix_valid,
    output logic                                                   pix_ready,
    output logic [((NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1)-1:0] pix_index,
    output logic                                                   busy,
    output logic                                                   frame_done,
    output logic                                                   underrun,
    output logic                                                   dout
);

    localparam int unsigned IdxW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int unsigned CycW = $clog2(TBIT);
    localparam int unsigned BitW = $clog2(BITS_PER_PIXEL);
    localparam int unsigned CntW = $clog2(NUM_PIXELS + 1);
    localparam int unsigned LatW = (TRESET > 1) ? $clog2(TRESET) : 1;

    localparam logic [CycW-1:0] CycLast = CycW'(TBIT - 1);
    localparam logic [CycW-1:0] T0hC    = CycW'(T0H);
    localparam logic [CycW-1:0] T1hC    = CycW'(T1H);
    localparam logic [BitW-1:0] BitLast = BitW'(BITS_PER_PIXEL - 1);
    localparam logic [CntW-1:0] PixLast = CntW'(NUM_PIXELS - 1);
    localparam logic [CntW-1:0] NumPix  = CntW'(NUM_PIXELS);
    localparam logic [LatW-1:0] LatLast = LatW'(TRESET - 1);

    typedef enum logic [1:0] {StIdle, StFirst, StSend, StLatch} state_e;

    state_e                    state_q, state_d;
    logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_d;
    logic [BITS_PER_PIXEL-1:0] buf_q, buf_d;
    logic                      buf_full_q, buf_full_d;
    logic [CycW-1:0]           cyc_q, cyc_d;
    logic [BitW-1:0]           bit_q, bit_d;
    // snt: pixel currently on the line; req: pixel slots requested or skipped so far
    logic [CntW-1:0]           snt_q, snt_d;
    logic [CntW-1:0]           req_q, req_d;
    logic [LatW-1:0]           lat_q, lat_d;
    logic                      xfer;
    logic [CntW-1:0]           idx_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cyc_q      <= '0;
            bit_q      <= '0;
            snt_q      <= '0;
            req_q      <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            snt_q      <= snt_d;
            req_q      <= req_d;
            lat_q      <= lat_d;
        end
    end

    // Once every slot is requested req_q reaches NUM_PIXELS; the index holds at the last pixel.
    assign idx_sat   = (req_q > PixLast) ? PixLast : req_q;
    assign pix_index = IdxW'(idx_sat);
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        snt_d      = snt_q;
        req_d      = req_q;
        lat_d      = lat_q;
        pix_ready  = 1'b0;
        xfer       = 1'b0;
        dout       = 1'b0;
        frame_done = 1'b0;
        underrun   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start || FREE_RUN) begin
                    state_d = StFirst;
                    req_d   = '0;
                end
            end

            StFirst: begin
                pix_ready = 1'b1;
                xfer      = pix_valid;
                if (xfer) begin
                    shreg_d    = pix_data;
                    buf_full_d = 1'b0;
                    cyc_d      = '0;
                    bit_d      = '0;
                    snt_d      = '0;
                    req_d      = req_q + 1'b1;
                    state_d    = StSend;
                end
            end

            StSend: begin
                pix_ready = !buf_full_q && (req_q < NumPix);
                xfer      = pix_ready && pix_valid;
                dout      = cyc_q < (shreg_q[BITS_PER_PIXEL-1] ? T1hC : T0hC);
                if (xfer) begin
                    buf_d      = pix_data;
                    buf_full_d = 1'b1;
                    req_d      = req_q + 1'b1;
                end
                if (cyc_q == CycLast) begin
                    cyc_d = '0;
                    if (bit_q == BitLast) begin
                        bit_d = '0;
                        if (snt_q == PixLast) begin
                            shreg_d = '0;
                            lat_d   = '0;
                            state_d = StLatch;
                        end else begin
                            snt_d = snt_q + 1'b1;
                            if (buf_full_q) begin
                                shreg_d    = buf_q;
                                buf_full_d = 1'b0;
                            end else if (xfer) begin
                                // Word arriving exactly on the boundary goes straight to the line.
                                shreg_d    = pix_data;
                                buf_full_d = 1'b0;
                            end else begin
                                // Skip the missing slot so the next request is for the next pixel.
                                shreg_d  = '0;
                                underrun = 1'b1;
                                req_d    = req_q + 1'b1;
                            end
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            StLatch: begin
                if (lat_q == LatLast) begin
                    frame_done = 1'b1;
                    lat_d      = '0;
                    if (FREE_RUN) begin
                        state_d = StFirst;
                        req_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// Testbench for ws2812_frame_streamer. Instance A: 8 GRB pixels, start-triggered.
// Instance B: 2 GRBW pixels, free-running. The line waveform is predicted per cycle from the
// pixel words with plain arithmetic (pixel, bit and in-bit cycle derived from the frame offset).
`timescale 1ns/1ps
module tb_ws2812_frame_streamer;

    localparam int T0H  = 17;
    localparam int T1H  = 35;
    localparam int TBIT = 62;
    localparam int NA   = 8;
    localparam int BA   = 24;
    localparam int TRA  = 200;
    localparam int NB   = 2;
    localparam int BB   = 32;
    localparam int TRB  = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic          rst_a, start_a, valid_en_a;
    logic [BA-1:0] mem_a [NA];
    logic [NA-1:0] drop_a;
    logic [BA-1:0] pix_data_a;
    logic          pix_valid_a, pix_ready_a, busy_a, frame_done_a, underrun_a, dout_a;
    logic [2:0]    pix_index_a;

    assign pix_data_a  = mem_a[pix_index_a];
    assign pix_valid_a = valid_en_a && !drop_a[pix_index_a];

    ws2812_frame_streamer #(
        .NUM_PIXELS(NA), .BITS_PER_PIXEL(BA), .T0H(T0H), .T1H(T1H), .TBIT(TBIT),
        .TRESET(TRA), .FREE_RUN(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .pix_data(pix_data_a),
        .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .pix_index(pix_index_a),
        .busy(busy_a), .frame_done(frame_done_a), .underrun(underrun_a), .dout(dout_a)
    );

    // Instance B
    logic          rst_b, start_b, valid_b;
    logic [BB-1:0] mem_b [NB];
    logic [BB-1:0] pix_data_b;
    logic          pix_ready_b, busy_b, frame_done_b, underrun_b, dout_b;
    logic [0:0]    pix_index_b;

    assign pix_data_b = mem_b[pix_index_b];

    ws2812_frame_streamer #(
        .NUM_PIXELS(NB), .BITS_PER_PIXEL(BB), .T0H(T0H), .T1H(T1H), .TBIT(TBIT),
        .TRESET(TRB), .FREE_RUN(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .pix_data(pix_data_b),
        .pix_valid(valid_b), .pix_ready(pix_ready_b), .pix_index(pix_index_b),
        .busy(busy_b), .frame_done(frame_done_b), .underrun(underrun_b), .dout(dout_b)
    );

    int checks   = 0;
    int failures = 0;

    // Expected frame content: word per pixel, and which pixels are replaced by black.
    logic [31:0] exp_words [8];
    logic [7:0]  exp_drop;

    typedef struct {
        logic [7:0] drop;
        int         delay;
        bit         rnd;
        bit         poke;
        int         exp_und;
    } row_t;
    row_t rows [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic s_dout(input int w);
        return (w == 0) ? dout_a : dout_b;
    endfunction
    function automatic logic s_und(input int w);
        return (w == 0) ? underrun_a : underrun_b;
    endfunction
    function automatic logic s_done(input int w);
        return (w == 0) ? frame_done_a : frame_done_b;
    endfunction
    function automatic logic s_ready(input int w);
        return (w == 0) ? pix_ready_a : pix_ready_b;
    endfunction
    function automatic logic s_busy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction
    function automatic int s_idx(input int w);
        return (w == 0) ? int'(pix_index_a) : int'(pix_index_b);
    endfunction

    // Entered on the negedge where dout has just gone high (frame offset 0). Returns on the
    // first negedge after the latch gap.
    task automatic run_wave(input int w, input int npix, input int bpp, input int treset,
                            input bit poke, output int und_seen);
        int          ppix, errs, und_err, p, b, c, lat_hi, done_err, done_cnt, ctl_err;
        int          idx_last;
        logic [31:0] word;
        bit          v, e, eu;
        ppix = bpp * TBIT;
        errs = 0; und_err = 0; und_seen = 0;
        lat_hi = 0; done_err = 0; done_cnt = 0; ctl_err = 0; idx_last = -1;
        for (int k = 0; k < npix * ppix; k++) begin
            p    = k / ppix;
            b    = (k / TBIT) % bpp;
            c    = k % TBIT;
            word = exp_drop[p] ? 32'h0 : exp_words[p];
            v    = word[bpp-1-b];
            e    = (c < (v ? T1H : T0H));
            eu   = (c == TBIT - 1) && (b == bpp - 1) && (p + 1 < npix) && exp_drop[p+1];
            if (s_dout(w) !== e) errs++;
            if (s_und(w) !== eu) und_err++;
            if (s_und(w) === 1'b1) und_seen++;
            if (s_done(w) !== 1'b0) done_err++;
            if (poke) start_a = (k == 2 * ppix + 7);
            @(negedge clk);
        end
        check("wave_dout_errors", errs, 0);
        check("underrun_position_errors", und_err, 0);
        for (int l = 0; l < treset; l++) begin
            if (s_dout(w) !== 1'b0) lat_hi++;
            if (s_done(w) === 1'b1) done_cnt++;
            if (s_done(w) !== 1'(l == treset - 1)) done_err++;
            if (s_ready(w) !== 1'b0 || s_busy(w) !== 1'b1) ctl_err++;
            if (l == treset - 1) idx_last = s_idx(w);
            if (poke) start_a = (l == treset / 2);
            @(negedge clk);
        end
        if (poke) start_a = 1'b0;
        check("latch_dout_high_cycles", lat_hi, 0);
        check("frame_done_count", done_cnt, 1);
        check("frame_done_timing_errors", done_err, 0);
        check("latch_ready_busy_errors", ctl_err, 0);
        check("latch_pix_index", idx_last, npix - 1);
    endtask

    task automatic run_row(input row_t r);
        int hold_err, rises, und_seen;
        bit found;
        drop_a = r.drop;
        for (int p = 0; p < NA; p++) begin
            mem_a[p]     = r.rnd ? 24'($urandom) : 24'hAA00FF;
            exp_words[p] = 32'(mem_a[p]);
        end
        exp_drop   = r.drop;
        valid_en_a = 1'b0;
        start_a    = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("first_busy", int'(busy_a), 1);
        check("first_ready", int'(pix_ready_a), 1);
        check("first_index", int'(pix_index_a), 0);
        hold_err = 0;
        for (int d = 0; d < r.delay; d++) begin
            if (dout_a !== 1'b0 || pix_ready_a !== 1'b1) hold_err++;
            @(negedge clk);
        end
        check("first_hold_errors", hold_err, 0);
        valid_en_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dout_a === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("first_rise_seen", int'(found), 1);
        if (!found) return;
        run_wave(0, NA, BA, TRA, r.poke, und_seen);
        check("underrun_count", und_seen, r.exp_und);
        check("idle_after_latch_busy", int'(busy_a), 0);
        check("idle_pix_index_held", int'(pix_index_a), NA - 1);
        rises = 0;
        for (int i = 0; i < 50; i++) begin
            if (dout_a !== 1'b0 || frame_done_a !== 1'b0) rises++;
            @(negedge clk);
        end
        check("no_extra_frame", rises, 0);
    endtask

    initial begin
        int  highs, und_seen;
        bit  found;

        rows[0] = '{8'h00, 0,  1'b0, 1'b1, 0};
        rows[1] = '{8'h20, 3,  1'b1, 1'b0, 1};
        rows[2] = '{8'h86, 0,  1'b1, 1'b1, 3};
        rows[3] = '{8'h00, 17, 1'b1, 1'b0, 0};
        rows[4] = '{8'hFE, 0,  1'b1, 1'b0, 7};

        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        valid_en_a = 1'b0; valid_b = 1'b1; drop_a = '0;
        for (int p = 0; p < NA; p++) mem_a[p] = 24'hAA00FF;
        mem_b[0] = 32'h80000001;
        mem_b[1] = 32'h00000000;
        repeat (3) @(negedge clk);

        check("rst_dout", int'(dout_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_ready", int'(pix_ready_a), 0);
        check("rst_index", int'(pix_index_a), 0);
        check("rst_done", int'(frame_done_a), 0);
        check("rst_underrun", int'(underrun_a), 0);
        check("rst_b_busy", int'(busy_b), 0);

        rst_a = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy_a), 0);
        check("idle_ready", int'(pix_ready_a), 0);

        for (int r = 0; r < 5; r++) run_row(rows[r]);

        // Reset in the middle of pixel 3, bit 10.
        drop_a = '0;
        for (int p = 0; p < NA; p++) mem_a[p] = 24'($urandom) | 24'h800000;
        start_a = 1'b1;
        @(negedge clk);
        start_a    = 1'b0;
        valid_en_a = 1'b1;
        repeat (1 + 3 * BA * TBIT + 10 * TBIT + 5) @(negedge clk);
        check("pre_reset_busy", int'(busy_a), 1);
        rst_a = 1'b0;
        #1;
        check("abort_dout", int'(dout_a), 0);
        check("abort_busy", int'(busy_a), 0);
        check("abort_ready", int'(pix_ready_a), 0);
        check("abort_index", int'(pix_index_a), 0);
        check("abort_done", int'(frame_done_a), 0);
        check("abort_underrun", int'(underrun_a), 0);
        @(negedge clk);
        rst_a = 1'b1;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            if (dout_a !== 1'b0 || busy_a !== 1'b0) highs++;
            @(negedge clk);
        end
        check("post_abort_quiet", highs, 0);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a   = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("start_on_release_busy", int'(busy_a), 1);
        check("start_on_release_index", int'(pix_index_a), 0);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a      = 1'b1;
        valid_en_a = 1'b0;

        // Free-running GRBW instance.
        rst_b = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dout_b === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("b_first_rise_seen", int'(found), 1);
        if (found) begin
            for (int f = 0; f < 3; f++) begin
                exp_drop = '0;
                for (int p = 0; p < NB; p++) exp_words[p] = mem_b[p];
                run_wave(1, NB, BB, TRB, 1'b0, und_seen);
                check("b_underrun_count", und_seen, 0);
                check("b_refirst_busy", int'(busy_b), 1);
                check("b_refirst_index", int'(pix_index_b), 0);
                check("b_refirst_dout", int'(dout_b), 0);
                mem_b[0] = $urandom;
                mem_b[1] = $urandom;
                @(negedge clk);
                check("b_next_frame_rise", int'(dout_b), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
